// File: rtl/prt_pkg.sv
// Shared constants, FSM state type and slot descriptor for the packet reference table
// and its ingress writer.
package prt_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_SLOTS  = 2;
  localparam int MAX_BYTES  = 1518;
  localparam int SLOT_W     = $clog2(NUM_SLOTS);
  localparam int LEN_W      = $clog2(MAX_BYTES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPEN,
    ST_WRITE,
    ST_CLOSE,
    ST_PUBLISH
  } prt_state_e;

  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [LEN_W-1:0]  len;
    logic              trunc;
  } prt_desc_t;
endpackage

// File: rtl/prt_ingress_writer.sv
// Ingress writer: takes one byte-stream frame at a time, stores it into a free PRT slot
// and publishes a {slot, len, trunc} descriptor downstream.
module prt_ingress_writer
  import prt_pkg::*;
#(
  parameter int DATA_WIDTH = prt_pkg::DATA_WIDTH,
  parameter int NUM_SLOTS  = prt_pkg::NUM_SLOTS,
  parameter int MAX_BYTES  = prt_pkg::MAX_BYTES,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  is_prt_slot_free,
  input  logic                  RDY_is_prt_slot_free,
  output logic                  EN_start_writing_prt_entry,
  input  logic                  RDY_start_writing_prt_entry,
  input  logic [SLOT_W-1:0]     start_writing_prt_entry,
  output logic                  EN_write_prt_entry,
  output logic [DATA_WIDTH-1:0] write_prt_entry_data,
  input  logic                  RDY_write_prt_entry,
  output logic                  EN_finish_writing_prt_entry,
  input  logic                  RDY_finish_writing_prt_entry,
  output logic                  d_valid,
  input  logic                  d_ready,
  output logic [SLOT_W-1:0]     d_slot,
  output logic [LEN_W-1:0]      d_len,
  output logic                  d_trunc,
  output logic [15:0]           frame_count
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BYTES);

  prt_state_e        state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              trunc_q, trunc_d;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              at_cap;

  assign at_cap               = (len_q == LEN_MAX);
  assign write_prt_entry_data = s_data;
  assign d_slot               = slot_q;
  assign d_len                = len_q;
  assign d_trunc              = trunc_q;
  assign frame_count          = fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= '0;
      len_q   <= '0;
      trunc_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d                     = state_q;
    slot_d                      = slot_q;
    len_d                       = len_q;
    trunc_d                     = trunc_q;
    fcnt_d                      = fcnt_q;
    s_ready                     = 1'b0;
    EN_start_writing_prt_entry  = 1'b0;
    EN_write_prt_entry          = 1'b0;
    EN_finish_writing_prt_entry = 1'b0;
    d_valid                     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_valid && is_prt_slot_free && RDY_is_prt_slot_free) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        EN_start_writing_prt_entry = RDY_start_writing_prt_entry;
        if (RDY_start_writing_prt_entry) begin
          slot_d  = start_writing_prt_entry;
          len_d   = '0;
          trunc_d = 1'b0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Once the entry is full the tail is drained without waiting on the PRT.
        if (at_cap) begin
          s_ready = 1'b1;
          if (s_valid) trunc_d = 1'b1;
        end else begin
          s_ready            = RDY_write_prt_entry;
          EN_write_prt_entry = s_valid && RDY_write_prt_entry;
          if (EN_write_prt_entry) len_d = len_q + LEN_W'(1);
        end
        if (s_valid && s_ready && s_last) state_d = ST_CLOSE;
      end
      ST_CLOSE: begin
        EN_finish_writing_prt_entry = RDY_finish_writing_prt_entry;
        if (RDY_finish_writing_prt_entry) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        d_valid = 1'b1;
        if (d_ready) begin
          fcnt_d  = fcnt_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prt_ingress_writer.sv
// Bench for prt_ingress_writer with a 4-byte entry capacity; the bench plays the PRT
// and the classifier and predicts writes and descriptors from the frame contents.
module tb_prt_ingress_writer;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int SW = 1;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic          is_prt_slot_free = 1'b1, RDY_is_prt_slot_free = 1'b1;
  logic          EN_start_writing_prt_entry, RDY_start_writing_prt_entry = 1'b1;
  logic [SW-1:0] start_writing_prt_entry = '0;
  logic          EN_write_prt_entry, RDY_write_prt_entry = 1'b1;
  logic [DW-1:0] write_prt_entry_data;
  logic          EN_finish_writing_prt_entry, RDY_finish_writing_prt_entry = 1'b1;
  logic          d_valid, d_ready = 1'b1, d_trunc;
  logic [SW-1:0] d_slot;
  logic [LW-1:0] d_len;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  prt_ingress_writer #(.DATA_WIDTH(DW), .NUM_SLOTS(2), .MAX_BYTES(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .is_prt_slot_free(is_prt_slot_free), .RDY_is_prt_slot_free(RDY_is_prt_slot_free),
    .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
    .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
    .start_writing_prt_entry(start_writing_prt_entry),
    .EN_write_prt_entry(EN_write_prt_entry), .write_prt_entry_data(write_prt_entry_data),
    .RDY_write_prt_entry(RDY_write_prt_entry),
    .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
    .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
    .d_valid(d_valid), .d_ready(d_ready), .d_slot(d_slot), .d_len(d_len),
    .d_trunc(d_trunc), .frame_count(frame_count)
  );

  int total = 0, bad = 0;
  int cyc = 0, sv_cyc = 0, fc_exp = 0;
  bit rnd = 1'b0;
  int stall_cnt = 0, stall_after = 0;

  // Observation log, written only by the monitor.
  logic [DW-1:0] wr_log[$];
  int            wr_cyc[$];
  int            n_start = 0, n_finish = 0, n_desc = 0, st_cyc = 0, en_viol = 0;
  logic [SW-1:0] desc_slot = '0;
  logic [LW-1:0] desc_len = '0;
  logic          desc_trunc = 1'b0;

  always @(negedge clk) if (rst_n) begin
    if (EN_write_prt_entry) begin
      wr_log.push_back(write_prt_entry_data);
      wr_cyc.push_back(cyc);
    end
    if (EN_start_writing_prt_entry) begin n_start++; st_cyc = cyc; end
    if (EN_finish_writing_prt_entry) n_finish++;
    if (d_valid && d_ready) begin
      n_desc++; desc_slot = d_slot; desc_len = d_len; desc_trunc = d_trunc;
    end
    if ((EN_start_writing_prt_entry && !RDY_start_writing_prt_entry) ||
        (EN_write_prt_entry && !RDY_write_prt_entry) ||
        (EN_finish_writing_prt_entry && !RDY_finish_writing_prt_entry)) en_viol++;
  end

  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (rnd) begin
      RDY_is_prt_slot_free         = $urandom_range(0, 3) != 0;
      RDY_start_writing_prt_entry  = $urandom_range(0, 1) != 0;
      RDY_write_prt_entry          = $urandom_range(0, 3) != 0;
      RDY_finish_writing_prt_entry = $urandom_range(0, 1) != 0;
      d_ready                      = $urandom_range(0, 1) != 0;
    end
    if (stall_cnt > 0 && wr_log.size() >= stall_after) begin
      RDY_write_prt_entry = 1'b0;
      stall_cnt--;
    end else if (!rnd) RDY_write_prt_entry = 1'b1;
  endtask

  task automatic send_frame(input logic [DW-1:0] b[$], input logic [SW-1:0] slot,
                            input bit with_last);
    logic acc;
    int t;
    start_writing_prt_entry = slot;
    sv_cyc = cyc;
    for (int i = 0; i < b.size(); i++) begin
      s_valid = 1'b1; s_data = b[i]; s_last = with_last && (i == b.size() - 1);
      acc = 1'b0; t = 0;
      while (!acc && t < 300) begin
        @(negedge clk); acc = s_ready; step(); t++;
      end
      if (!acc) begin
        total++; bad++;
        $display("FAIL send_timeout byte=%0d waited=%0d cycles, needed accept", i, t);
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic wait_desc(input int d0);
    int t = 0;
    while (n_desc == d0 && t < 300) begin step(); t++; end
    if (n_desc == d0) begin
      total++; bad++;
      $display("FAIL desc_timeout no descriptor after %0d cycles", t);
    end
  endtask

  task automatic test_reset();
    s_valid = 1'b1; s_data = 8'h5A;
    #1;
    total++;
    if ({s_ready, EN_start_writing_prt_entry, EN_write_prt_entry,
         EN_finish_writing_prt_entry, d_valid, d_slot, d_len, d_trunc} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b need=0", {s_ready, EN_start_writing_prt_entry,
        EN_write_prt_entry, EN_finish_writing_prt_entry, d_valid, d_slot, d_len, d_trunc});
    end
    total++;
    if (frame_count !== 16'd0) begin
      bad++; $display("FAIL reset_fcount got=%0d need=0", frame_count);
    end
    s_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [DW-1:0] b[$] = '{8'h11, 8'h22, 8'h33};
    int base = wr_log.size(), s0 = n_start, f0 = n_finish, d0 = n_desc;
    bit ok;
    send_frame(b, 1'b1, 1'b1);
    wait_desc(d0);
    fc_exp++;
    ok = (wr_log.size() == base + 3);
    for (int i = 0; i < 3 && ok; i++) ok = (wr_log[base + i] == b[i]);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_writes got=%0d writes need=3 (11,22,33)", wr_log.size() - base); end
    total++;
    if (wr_cyc.size() > base && wr_cyc[base] !== sv_cyc + 2) begin
      bad++; $display("FAIL basic_latency got=%0d need=%0d", wr_cyc[base] - sv_cyc, 2);
    end
    total++;
    if (n_start - s0 != 1 || n_finish - f0 != 1) begin
      bad++; $display("FAIL basic_open_close got=%0d/%0d need=1/1", n_start - s0, n_finish - f0);
    end
    total++;
    if ({desc_slot, desc_len, desc_trunc} !== {1'b1, 3'd3, 1'b0}) begin
      bad++; $display("FAIL basic_desc got=%0d/%0d/%0d need=1/3/0", desc_slot, desc_len, desc_trunc);
    end
    total++;
    if (frame_count !== 16'(fc_exp)) begin
      bad++; $display("FAIL basic_fcount got=%0d need=%0d", frame_count, fc_exp);
    end
  endtask

  task automatic test_one_byte();
    logic [DW-1:0] b[$] = '{8'hA5};
    int base = wr_log.size(), f0 = n_finish, d0 = n_desc;
    send_frame(b, 1'b0, 1'b1);
    wait_desc(d0);
    fc_exp++;
    total++;
    if (wr_log.size() != base + 1 || wr_log[base] !== 8'hA5) begin
      bad++; $display("FAIL onebyte_writes got=%0d writes need=1 of a5", wr_log.size() - base);
    end
    total++;
    if (n_finish - f0 != 1 || {desc_slot, desc_len, desc_trunc} !== {1'b0, 3'd1, 1'b0}) begin
      bad++; $display("FAIL onebyte_desc got=%0d/%0d/%0d fin=%0d need=0/1/0 fin=1",
                      desc_slot, desc_len, desc_trunc, n_finish - f0);
    end
    total++;
    if (frame_count !== 16'(fc_exp)) begin
      bad++; $display("FAIL onebyte_fcount got=%0d need=%0d", frame_count, fc_exp);
    end
  endtask

  task automatic test_no_free();
    logic [DW-1:0] b[$];
    int base, d0 = n_desc, busy = 0, c;
    bit ok;
    for (int i = 0; i < 3; i++) b.push_back(8'($urandom));
    base = wr_log.size();
    is_prt_slot_free = 1'b0;
    s_valid = 1'b1; s_data = b[0]; s_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ready || EN_start_writing_prt_entry || EN_write_prt_entry ||
          EN_finish_writing_prt_entry) busy++;
      step();
    end
    total++;
    if (busy != 0) begin bad++; $display("FAIL nofree_backpressure got=%0d active cycles need=0", busy); end
    is_prt_slot_free = 1'b1;
    c = cyc;
    send_frame(b, 1'b1, 1'b1);
    wait_desc(d0);
    fc_exp++;
    total++;
    if (st_cyc !== c + 1) begin bad++; $display("FAIL nofree_start_delay got=%0d need=1", st_cyc - c); end
    ok = (wr_log.size() == base + 3);
    for (int i = 0; i < 3 && ok; i++) ok = (wr_log[base + i] == b[i]);
    total++;
    if (!ok || {desc_slot, desc_len, desc_trunc} !== {1'b1, 3'd3, 1'b0}) begin
      bad++; $display("FAIL nofree_frame got=%0d writes len=%0d need=3 writes len=3",
                      wr_log.size() - base, desc_len);
    end
  endtask

  task automatic test_trunc();
    logic [DW-1:0] b[$];
    int base = wr_log.size(), d0 = n_desc;
    bit ok;
    for (int i = 0; i < 6; i++) b.push_back(8'($urandom));
    send_frame(b, 1'b0, 1'b1);
    wait_desc(d0);
    fc_exp++;
    ok = (wr_log.size() == base + MB);
    for (int i = 0; i < MB && ok; i++) ok = (wr_log[base + i] == b[i]);
    total++;
    if (!ok) begin bad++; $display("FAIL trunc_writes got=%0d need=%0d", wr_log.size() - base, MB); end
    total++;
    if ({desc_len, desc_trunc} !== {3'd4, 1'b1}) begin
      bad++; $display("FAIL trunc_desc got=len %0d trunc %0d need=len 4 trunc 1", desc_len, desc_trunc);
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] b[$];
    logic [SW+LW:0] snap;
    int base = wr_log.size(), d0 = n_desc, t = 0, unstable = 0;
    bit ok;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
    stall_after = base + 2; stall_cnt = 3;
    d_ready = 1'b0;
    send_frame(b, 1'b1, 1'b1);
    while (!d_valid && t < 100) begin step(); t++; end
    snap = {d_slot, d_len, d_trunc};
    for (int i = 0; i < 5; i++) begin
      step();
      if (!d_valid || s_ready || {d_slot, d_len, d_trunc} !== snap) unstable++;
    end
    total++;
    if (unstable != 0 || !d_valid) begin
      bad++; $display("FAIL stall_hold got=%0d unstable cycles need=0", unstable);
    end
    d_ready = 1'b1;
    wait_desc(d0);
    fc_exp++;
    ok = (wr_log.size() == base + 4);
    for (int i = 0; i < 4 && ok; i++) ok = (wr_log[base + i] == b[i]);
    total++;
    if (!ok) begin bad++; $display("FAIL stall_writes got=%0d need=4 exact bytes", wr_log.size() - base); end
    total++;
    if ({desc_slot, desc_len, desc_trunc} !== {1'b1, 3'd4, 1'b0} || frame_count !== 16'(fc_exp)) begin
      bad++; $display("FAIL stall_desc got=%0d/%0d/%0d fc=%0d need=1/4/0 fc=%0d",
                      desc_slot, desc_len, desc_trunc, frame_count, fc_exp);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = en_viol;
    rnd = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [DW-1:0] b[$];
      logic [SW-1:0] slot = SW'($urandom_range(0, 1));
      int n = $urandom_range(1, 7), exp_n, base = wr_log.size(), d0 = n_desc;
      bit ok;
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      exp_n = (n < MB) ? n : MB;
      send_frame(b, slot, 1'b1);
      wait_desc(d0);
      fc_exp++;
      ok = (wr_log.size() == base + exp_n);
      for (int i = 0; i < exp_n && ok; i++) ok = (wr_log[base + i] == b[i]);
      total++;
      if (!ok) begin bad++; $display("FAIL rand_writes frame=%0d got=%0d need=%0d", f, wr_log.size() - base, exp_n); end
      total++;
      if ({desc_slot, desc_len, desc_trunc} !== {slot, LW'(exp_n), n > MB}) begin
        bad++; $display("FAIL rand_desc frame=%0d got=%0d/%0d/%0d need=%0d/%0d/%0d", f,
                        desc_slot, desc_len, desc_trunc, slot, exp_n, n > MB);
      end
      total++;
      if (frame_count !== 16'(fc_exp)) begin
        bad++; $display("FAIL rand_fcount frame=%0d got=%0d need=%0d", f, frame_count, fc_exp);
      end
    end
    rnd = 1'b0;
    RDY_is_prt_slot_free = 1'b1; RDY_start_writing_prt_entry = 1'b1;
    RDY_write_prt_entry = 1'b1; RDY_finish_writing_prt_entry = 1'b1; d_ready = 1'b1;
    step();
    total++;
    if (en_viol != v0) begin bad++; $display("FAIL rand_en_gating got=%0d EN-without-RDY need=0", en_viol - v0); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] p[$] = '{8'hC1, 8'hC2};
    logic [DW-1:0] b[$] = '{8'h44, 8'h55};
    int base, d0;
    bit ok;
    send_frame(p, 1'b0, 1'b0);
    s_valid = 1'b1; s_data = 8'hC3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({EN_start_writing_prt_entry, EN_write_prt_entry, EN_finish_writing_prt_entry,
         d_valid, s_ready} !== 5'b0 || frame_count !== 16'd0) begin
      bad++; $display("FAIL midreset_outputs got=%b fc=%0d need=0 fc=0",
                      {EN_start_writing_prt_entry, EN_write_prt_entry,
                       EN_finish_writing_prt_entry, d_valid, s_ready}, frame_count);
    end
    s_valid = 1'b0;
    fc_exp = 0;
    step();
    rst_n = 1'b1;
    step();
    base = wr_log.size(); d0 = n_desc;
    send_frame(b, 1'b1, 1'b1);
    wait_desc(d0);
    fc_exp++;
    ok = (wr_log.size() == base + 2) && wr_log[base] == 8'h44 && wr_log[base + 1] == 8'h55;
    total++;
    if (!ok) begin bad++; $display("FAIL midreset_next_writes got=%0d need=2 (44,55)", wr_log.size() - base); end
    total++;
    if ({desc_slot, desc_len, desc_trunc} !== {1'b1, 3'd2, 1'b0} || frame_count !== 16'(fc_exp)) begin
      bad++; $display("FAIL midreset_next_desc got=%0d/%0d/%0d fc=%0d need=1/2/0 fc=%0d",
                      desc_slot, desc_len, desc_trunc, frame_count, fc_exp);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_basic();
    test_one_byte();
    test_no_free();
    test_trunc();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prt_ingress_writer.md
Name: prt_ingress_writer

Overview:
- Upstream feeder of the packet reference table (PRT); 1-byte-per-beat valid/ready/last ingress stream.
- Per frame: waits for a free PRT slot, opens it (start_writing_prt_entry), streams bytes into it (write_prt_entry), closes it (finish_writing_prt_entry).
- Publishes a slot descriptor (slot id, length, truncated flag) to the downstream classifier.
- Sole writer of the PRT; never drives invalidate or read methods.

Parameters:
- DATA_WIDTH, 8, byte width of stream and PRT write data.
- NUM_SLOTS, 2, PRT slot count; SLOT_W = $clog2(NUM_SLOTS).
- MAX_BYTES, 1518, PRT entry capacity in bytes; LEN_W = $clog2(MAX_BYTES+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  ingress byte valid
- s_data  in  DATA_WIDTH  ingress byte
- s_last  in  1  final byte of frame
- s_ready  out  1  ingress byte accepted when s_valid&&s_ready
- is_prt_slot_free  in  1  PRT has a free slot
- RDY_is_prt_slot_free  in  1  free-slot method ready
- EN_start_writing_prt_entry  out  1  open slot
- RDY_start_writing_prt_entry  in  1  open method ready
- start_writing_prt_entry  in  SLOT_W  slot index granted by PRT, valid with RDY_start
- EN_write_prt_entry  out  1  write one byte
- write_prt_entry_data  out  DATA_WIDTH  byte to write
- RDY_write_prt_entry  in  1  write method ready
- EN_finish_writing_prt_entry  out  1  close slot
- RDY_finish_writing_prt_entry  in  1  close method ready
- d_valid  out  1  descriptor valid
- d_ready  in  1  descriptor accepted
- d_slot  out  SLOT_W  slot written
- d_len  out  LEN_W  bytes stored (1..MAX_BYTES)
- d_trunc  out  1  frame exceeded MAX_BYTES
- frame_count  out  16  frames published, wraps at 2^16

Behaviour:
- Reset (rst_n low, async): state=IDLE; all EN_* 0; s_ready 0; d_valid 0; d_slot/d_len/d_trunc 0; frame_count 0; length counter 0. A frame in progress at reset is abandoned; the PRT is reset in the same domain.
- All EN_* are combinational, asserted only while the matching RDY_* is high and only in the owning state. Each EN is a one-cycle method call.
- FSM IDLE -> OPEN -> WRITE -> CLOSE -> PUBLISH -> IDLE.
- IDLE: s_ready=0. If s_valid && is_prt_slot_free && RDY_is_prt_slot_free, go to OPEN next cycle. No free slot: stay, backpressure (no drop).
- OPEN: EN_start=RDY_start. On fire, latch start_writing_prt_entry into slot_q, clear len, clear trunc -> WRITE.
- WRITE:
  - Below capacity (len<MAX_BYTES): s_ready=RDY_write; EN_write=s_valid&&RDY_write; write data=s_data; len++.
  - At capacity (len==MAX_BYTES): s_ready=1; bytes are consumed and discarded; EN_write=0; trunc set on the first discarded byte.
  - Accepted beat with s_last -> CLOSE, including a beat that is written or discarded in the same cycle.
- Minimum frame is 1 byte; the first accepted beat may carry s_last. First byte is written no earlier than 2 cycles after s_valid rises in IDLE.
- CLOSE: EN_finish=RDY_finish; on fire -> PUBLISH.
- PUBLISH: d_valid=1, holding d_slot=slot_q, d_len=len, d_trunc=trunc stable until d_ready. On d_valid&&d_ready: frame_count++ (wraps) -> IDLE.
- s_ready=0 in every state except WRITE. Throughput: one frame in flight.
- RDY deasserting mid-frame only stalls (EN stays 0, no state change). No data loss.

Decomposition:
- Package prt_pkg: DATA_WIDTH, NUM_SLOTS, MAX_BYTES, SLOT_W, LEN_W constants; FSM state enum; descriptor struct {slot, len, trunc}. The PRT module and its bench share this package.
- No sub-module needed; single FSM plus length counter. Optionally factor out prt_desc_reg (descriptor hold register with valid/ready).

Test Plan:
- Frame 0x11,0x22,0x33 (last on 0x33), slot free, PRT grants slot 1, all RDY high -> three EN_write with data 11,22,33; one EN_finish; descriptor slot=1 len=3 trunc=0; frame_count=1.
- 1-byte frame 0xA5 with s_last on first beat -> one write, finish, d_len=1.
- is_prt_slot_free=0 for 10 cycles with s_valid held -> s_ready=0 and no EN_* throughout; free rises -> EN_start 1 cycle later, frame completes intact.
- MAX_BYTES=4, 6-byte frame -> 4 EN_write; bytes 5–6 consumed with s_ready=1; d_len=4, d_trunc=1.
- RDY_write low for 3 cycles mid-frame, then d_ready held low 5 cycles -> no byte lost or duplicated; d_* stable while stalled; s_ready=0 until IDLE->OPEN->WRITE.
- rst_n asserted mid-WRITE -> immediately all EN_*=0, d_valid=0, frame_count=0; next frame after release is handled normally.
